// File: rtl/uart_tx_axis.sv
// rtl/uart_tx_axis.sv - UART transmitter fed by a ready/valid byte stream through a FIFO
// Purpose: queues bytes in a FIFO and sends each one as a UART frame: a start bit,
//   D0..D7 LSB first, an optional parity bit and 1 or 2 stop bits. Back-to-back
//   frames have no idle gap between them.
// Ports:
//   clk_i        in   system clock, rising edge
//   reset_i      in   synchronous active-high reset
//   valid_i      in   data_i holds a byte to send
//   data_i       in   byte to send
//   ready_o      out  FIFO not full; byte taken on an edge where valid_i & ready_o
//   tx_serial_o  out  UART line, idle high, registered
//   busy_o       out  FIFO non-empty or a frame is on the line
module uart_tx_axis #(
  parameter int CLK_FREQ_HZ     = 25_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_serial_o,
  output logic       busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int DEPTH        = 1 << FIFO_DEPTH_LOG2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  if (CLKS_PER_BIT < 2) begin : g_chk_clks
    $error("uart_tx_axis: CLKS_PER_BIT must be at least 2");
  end
  if (PARITY > 2 || PARITY < 0) begin : g_chk_parity
    $error("uart_tx_axis: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_tx_axis: STOP_BITS must be 1 or 2");
  end

  // FIFO
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       push;
  logic                       pop;
  logic [7:0]                 head;
  logic                       head_par;

  assign ready_o  = (count != FULL);
  assign push     = valid_i & ready_o;
  assign head     = mem[rd_ptr];
  assign head_par = (PARITY == 2) ? ~^head : ^head;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame FSM
  typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic          stop_idx, stop_idx_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic          tx, tx_n;
  logic          bit_done;
  logic          last_stop;

  assign bit_done    = (clk_cnt == '0);
  assign last_stop   = (STOP_BITS == 1) || stop_idx;
  assign tx_serial_o = tx;
  assign busy_o      = (state != IDLE) || (count != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      clk_cnt  <= clk_cnt_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      shift    <= shift_n;
      par      <= par_n;
      tx       <= tx_n;
    end
  end

  // tx_n is the line level for the state being entered, so the line changes on
  // the same edge as the state register.
  always_comb begin
    state_n    = state;
    clk_cnt_n  = clk_cnt;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    shift_n    = shift;
    par_n      = par;
    tx_n       = tx;
    pop        = 1'b0;
    if (state != IDLE) clk_cnt_n = clk_cnt - 1'b1;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (count != '0) begin
          pop       = 1'b1;
          shift_n   = head;
          par_n     = head_par;
          clk_cnt_n = BIT_LAST;
          state_n   = START;
          tx_n      = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_n   = DATA;
          bit_idx_n = 3'd0;
          clk_cnt_n = BIT_LAST;
          tx_n      = shift[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          clk_cnt_n = BIT_LAST;
          shift_n   = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            if (PARITY != 0) begin
              state_n = PAR_BIT;
              tx_n    = par;
            end else begin
              state_n    = STOP;
              stop_idx_n = 1'b0;
              tx_n       = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift[1];
          end
        end
      end
      PAR_BIT: begin
        if (bit_done) begin
          state_n    = STOP;
          stop_idx_n = 1'b0;
          clk_cnt_n  = BIT_LAST;
          tx_n       = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          clk_cnt_n = BIT_LAST;
          if (last_stop) begin
            // Chain straight into the next start bit when more bytes are queued.
            if (count != '0) begin
              pop     = 1'b1;
              shift_n = head;
              par_n   = head_par;
              state_n = START;
              tx_n    = 1'b0;
            end else begin
              state_n = IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            stop_idx_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_axis.sv
// tb/tb_uart_tx_axis.sv - self-checking bench for uart_tx_axis over all parity/stop combinations
module tb_uart_tx_axis;

  localparam int NCFG  = 6;
  localparam int CPB   = 10;
  localparam int NRAND = 170;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [NCFG];
  logic       valid [NCFG];
  logic [7:0] data  [NCFG];
  wire        ready [NCFG];
  wire        txs   [NCFG];
  wire        busy  [NCFG];
  wire [31:0] rx_cnt [NCFG];
  wire [31:0] pend   [NCFG];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void check(string nm, int k, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cfg=%0d actual=0x%0h required=0x%0h", nm, k, act, req);
    end
  endfunction

  // cfg index g: PARITY = g % 3, STOP_BITS = g / 3 + 1
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int PAR = g % 3;
    localparam int STP = g / 3 + 1;
    localparam int NB  = 9 + (PAR != 0 ? 1 : 0) + STP;

    logic [7:0] exp_mem [0:4095];
    int wr_idx   = 0;
    int rd_idx   = 0;
    int flush_wr = 0;
    int rst_gen  = 0;
    int rst_ack  = 0;
    int rx_count = 0;

    uart_tx_axis #(
      .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .PARITY(PAR),
      .STOP_BITS(STP), .FIFO_DEPTH_LOG2(4)
    ) dut (
      .clk_i(clk), .reset_i(rst[g]), .valid_i(valid[g]), .data_i(data[g]),
      .ready_o(ready[g]), .tx_serial_o(txs[g]), .busy_o(busy[g])
    );

    assign rx_cnt[g] = rx_count;
    assign pend[g]   = wr_idx - rd_idx;

    // Scoreboard: record every accepted byte; a reset discards everything queued.
    always @(posedge clk) begin
      if (rst[g]) begin
        rst_gen  <= rst_gen + 1;
        flush_wr <= wr_idx;
      end else if (valid[g] && ready[g]) begin
        exp_mem[wr_idx[11:0]] <= data[g];
        wr_idx <= wr_idx + 1;
      end
    end

    // UART receiver: detect start, sample each bit in its middle.
    initial begin
      int ph, j;
      logic act;
      logic [11:0] sh, want;
      logic [7:0] d;
      act = 1'b0; ph = 0; sh = '0;
      forever begin
        @(negedge clk);
        if (rst_ack != rst_gen) begin
          rst_ack = rst_gen;
          act     = 1'b0;
          rd_idx  = flush_wr;
        end else if (!act) begin
          if (txs[g] === 1'b0) begin
            act = 1'b1; ph = 0; sh = '0;
          end
        end else begin
          ph++;
          if (ph % CPB == CPB / 2) begin
            j = ph / CPB;
            sh[j] = txs[g];
            if (j == NB - 1) begin
              act = 1'b0;
              rx_count++;
              check("rx_byte_expected", g, (wr_idx != rd_idx), 1);
              if (wr_idx != rd_idx) begin
                d = exp_mem[rd_idx[11:0]];
                rd_idx++;
                want = '1;
                want[0] = 1'b0;
                want[8:1] = d;
                if (PAR == 1) want[9] = ^d;
                if (PAR == 2) want[9] = ~^d;
                want = want & (12'hFFF >> (12 - NB));
                check("rx_frame", g, sh, want);
              end
            end
          end
        end
      end
    end
  end

  typedef struct {
    int         cfg;
    logic [7:0] d;
    logic [11:0] bits;
    int         nbits;
    int         flen;
  } vec_t;

  vec_t vecs [6];

  // Starts and ends on a negedge; returns on the negedge after the accept edge.
  task automatic send(int k, logic [7:0] b);
    int n;
    n = 0;
    valid[k] = 1'b1;
    data[k]  = b;
    while (!ready[k] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("send_timeout", k, n, 0);
    @(negedge clk);
    valid[k] = 1'b0;
  endtask

  task automatic wait_idle(int k);
    int n;
    n = 0;
    while (busy[k] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("idle_timeout", k, n, 0);
  endtask

  task automatic rand_drive(int k, int nbytes);
    int sent, guard;
    sent = 0; guard = 0;
    while (sent < nbytes && guard < 60000) begin
      valid[k] = ($urandom_range(0, 3) != 0);
      data[k]  = 8'($urandom);
      if (valid[k] && ready[k]) sent++;
      @(negedge clk);
      guard++;
    end
    valid[k] = 1'b0;
    check("rand_sent", k, sent, nbytes);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cfg=-1 actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, lows, h, rc;
    int rc_arr [NCFG];
    logic [11:0] got;
    logic all_idle;

    vecs[0] = '{0, 8'hA5, 12'h34A, 10, 100};
    vecs[1] = '{1, 8'h07, 12'h60E, 11, 110};
    vecs[2] = '{2, 8'h07, 12'h40E, 11, 110};
    vecs[3] = '{3, 8'h3C, 12'h678, 11, 110};
    vecs[4] = '{4, 8'h80, 12'hF00, 12, 120};
    vecs[5] = '{5, 8'h00, 12'hE00, 12, 120};

    for (int k = 0; k < NCFG; k++) begin
      rst[k] = 1'b1; valid[k] = 1'b0; data[k] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NCFG; k++) rst[k] = 1'b0;
    for (int k = 0; k < NCFG; k++) begin
      check("reset_tx", k, txs[k], 1);
      check("reset_ready", k, ready[k], 1);
      check("reset_busy", k, busy[k], 0);
    end

    // Single frames, one per configuration
    for (int v = 0; v < 6; v++) begin
      int k;
      k  = vecs[v].cfg;
      rc = rx_cnt[k];
      send(k, vecs[v].d);
      check("tx_before_start", k, txs[k], 1);
      check("busy_after_accept", k, busy[k], 1);
      @(negedge clk);
      check("start_latency", k, txs[k], 0);
      got = '0;
      for (int i = 1; i <= vecs[v].flen; i++) begin
        @(negedge clk);
        if (i % CPB == CPB / 2) got[i / CPB] = txs[k];
        if (i == vecs[v].flen - 1) check("busy_last_cycle", k, busy[k], 1);
        if (i == vecs[v].flen) begin
          check("busy_after_frame", k, busy[k], 0);
          check("tx_after_frame", k, txs[k], 1);
        end
      end
      check("frame_bits", k, got, vecs[v].bits);
      check("frame_count", k, rx_cnt[k] - rc, 1);
    end

    // valid held: FIFO fill level and back-to-back frames
    rc = rx_cnt[0];
    n = 0; acc = 0;
    valid[0] = 1'b1; data[0] = 8'h00;
    while (ready[0] && acc < 40) begin
      @(negedge clk);
      n++; acc++;
      data[0] = 8'(acc);
    end
    valid[0] = 1'b0;
    check("accepted_before_full", 0, acc, 17);
    while (busy[0] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("burst_busy_cycles", 0, n, 1702);
    check("burst_frames", 0, rx_cnt[0] - rc, 17);
    check("burst_pending", 0, pend[0], 0);

    // Two stop bits: line high between frames
    rc = rx_cnt[3];
    send(3, 8'h00);
    send(3, 8'hFF);
    n = 0;
    while (txs[3] !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    while (txs[3] === 1'b0 && n < 200) begin @(negedge clk); n++; end
    h = 0;
    while (txs[3] === 1'b1 && h < 100) begin @(negedge clk); h++; end
    check("stop2_high_gap", 3, h, 20);
    wait_idle(3);
    check("stop2_frames", 3, rx_cnt[3] - rc, 2);

    // Reset in the middle of a frame with bytes queued
    rc = rx_cnt[0];
    valid[0] = 1'b1; data[0] = 8'h01;
    @(negedge clk); data[0] = 8'h02;
    @(negedge clk); data[0] = 8'h03;
    @(negedge clk); valid[0] = 1'b0;
    repeat (44) @(negedge clk);
    check("mid_frame_busy", 0, busy[0], 1);
    check("mid_frame_d3", 0, txs[0], 0);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("reset_mid_tx", 0, txs[0], 1);
    check("reset_mid_busy", 0, busy[0], 0);
    check("reset_mid_ready", 0, ready[0], 1);
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (txs[0] !== 1'b1) lows++;
    end
    check("no_frames_after_reset", 0, lows, 0);
    check("reset_rx_frames", 0, rx_cnt[0] - rc, 0);
    check("reset_pending", 0, pend[0], 0);

    // Random traffic on every configuration at once
    for (int k = 0; k < NCFG; k++) rc_arr[k] = rx_cnt[k];
    fork
      rand_drive(0, NRAND);
      rand_drive(1, NRAND);
      rand_drive(2, NRAND);
      rand_drive(3, NRAND);
      rand_drive(4, NRAND);
      rand_drive(5, NRAND);
    join
    n = 0;
    all_idle = 1'b0;
    while (!all_idle && n < 3000) begin
      @(negedge clk);
      n++;
      all_idle = 1'b1;
      for (int k = 0; k < NCFG; k++) if (busy[k]) all_idle = 1'b0;
    end
    check("rand_idle", -1, all_idle, 1);
    for (int k = 0; k < NCFG; k++) begin
      check("rand_frames", k, rx_cnt[k] - rc_arr[k], NRAND);
      check("rand_pending", k, pend[k], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
